// File: rtl/axi4_pkg.sv
// Shared AXI4 write-master types: FSM states, AXI burst/response encodings and the 4 KiB check.
package axi4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AXI forbids a burst from touching two 4 KiB pages; landing exactly on 4096 is still legal.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input logic [7:0]  len,
                                      input int unsigned beat_bytes);
    int unsigned end_byte;
    end_byte = 32'(addr_lo) + (32'(len) + 32'd1) * beat_bytes;
    return (end_byte > 32'd4096);
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle; the write master drives AW/W/BREADY and ties the read side inactive.
interface axi4_if #(
  parameter int DW = 64,
  parameter int AW = 32,
  parameter int IW = 4
);
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic [3:0]      awregion;
  logic            awvalid;
  logic            awready;
  logic [IW-1:0]   wid;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IW-1:0]   arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport m (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_wr_master.sv
// Single-outstanding AXI4 INCR write master: command -> AW -> W stream (zero-latency pass-through) -> B.
// Backpressure: cmd_ready_o only in IDLE; dat_ready_o mirrors WREADY during DATA; done_o/err_o lag one cycle.
module axi4_wr_master
  import axi4_pkg::*;
#(
  parameter int DW      = 64,
  parameter int AW      = 32,
  parameter int IW      = 4,
  parameter int WID_VAL = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [7:0]    cmd_len_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [DW-1:0] dat_i,
  input  logic          dat_valid_i,
  output logic          dat_ready_o,
  output logic          done_o,
  output logic [1:0]    resp_o,
  output logic          err_o,
  axi4_if.m             axi_o
);

  localparam int BEAT_BYTES = DW / 8;
  localparam int SIZE       = $clog2(BEAT_BYTES);

  wr_state_e     state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q;
  logic [7:0]    beat_cnt;
  logic          cmd_fire, cmd_bad, beat_fire, last_beat, b_fire;
  logic          aw_vld, w_vld, b_rdy;
  logic          unused_axi;

  assign cmd_fire  = (state == ST_IDLE) && cmd_valid_i;
  assign cmd_bad   = (cmd_addr_i[SIZE-1:0] != '0) ||
                     crosses_4k(cmd_addr_i[11:0], cmd_len_i, BEAT_BYTES);
  assign last_beat = (beat_cnt == len_q);
  assign beat_fire = (state == ST_DATA) && dat_valid_i && axi_o.wready;
  assign b_fire    = (state == ST_RESP) && axi_o.bvalid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready_o = 1'b0;
    dat_ready_o = 1'b0;
    aw_vld      = 1'b0;
    w_vld       = 1'b0;
    b_rdy       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        // Bad commands are swallowed here so they never reach the bus.
        if (cmd_fire && !cmd_bad) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        aw_vld = 1'b1;
        if (axi_o.awready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_vld       = dat_valid_i;
        dat_ready_o = axi_o.wready;
        if (beat_fire && last_beat) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        b_rdy = 1'b1;
        if (axi_o.bvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      resp_o   <= 2'b00;
    end else begin
      done_o <= b_fire;
      err_o  <= (cmd_fire && cmd_bad) || (b_fire && (axi_o.bresp != RESP_OKAY));
      if (cmd_fire && !cmd_bad) begin
        addr_q   <= cmd_addr_i;
        len_q    <= cmd_len_i;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (b_fire) resp_o <= axi_o.bresp;
    end
  end

  assign axi_o.awid     = IW'(WID_VAL);
  assign axi_o.awaddr   = addr_q;
  assign axi_o.awlen    = len_q;
  assign axi_o.awsize   = 3'(SIZE);
  assign axi_o.awburst  = BURST_INCR;
  assign axi_o.awlock   = 1'b0;
  assign axi_o.awcache  = 4'd0;
  assign axi_o.awprot   = 3'd0;
  assign axi_o.awqos    = 4'd0;
  assign axi_o.awregion = 4'd0;
  assign axi_o.awvalid  = aw_vld;

  assign axi_o.wid      = IW'(WID_VAL);
  assign axi_o.wdata    = dat_i;
  assign axi_o.wstrb    = '1;
  assign axi_o.wlast    = last_beat;
  assign axi_o.wvalid   = w_vld;
  assign axi_o.bready   = b_rdy;

  assign axi_o.arid     = '0;
  assign axi_o.araddr   = '0;
  assign axi_o.arlen    = 8'd0;
  assign axi_o.arsize   = 3'd0;
  assign axi_o.arburst  = 2'b00;
  assign axi_o.arvalid  = 1'b0;
  assign axi_o.rready   = 1'b0;

  // BID is not compared: with one burst in flight any B belongs to it.
  assign unused_axi = ^{axi_o.bid, axi_o.arready, axi_o.rid, axi_o.rdata,
                        axi_o.rresp, axi_o.rlast, axi_o.rvalid};

endmodule

// File: tb/tb_axi4_wr_master.sv
// Scoreboard bench for axi4_wr_master: random data per burst is queued as expected, W beats are queued as observed.
module tb_axi4_wr_master;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] dat;
  logic          dat_valid, dat_ready;
  logic          done, err;
  logic [1:0]    resp;

  always #5 clk = ~clk;

  axi4_if #(.DW(DW), .AW(AW), .IW(IW)) axi ();

  axi4_wr_master #(.DW(DW), .AW(AW), .IW(IW), .WID_VAL(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .dat_i(dat), .dat_valid_i(dat_valid), .dat_ready_o(dat_ready),
    .done_o(done), .resp_o(resp), .err_o(err),
    .axi_o(axi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] src [0:256];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  logic          last_q [$];

  int            aw_cycles, done_cnt, err_cnt, rdy_outside;
  logic          timeout, err_with_done, rdy_at_done;
  logic [1:0]    resp_at_done;
  logic [AW-1:0] seen_awaddr;
  logic [7:0]    seen_awlen;
  logic [2:0]    seen_awsize;
  logic [1:0]    seen_awburst;
  logic [5:0]    abort_snap;

  // Drives one command and plays the slave; a burst abandoned by reset returns right after the reset.
  task automatic run_cmd(input logic [AW-1:0] a, input logic [7:0] l, input int aw_pct,
                         input int w_pct, input int v_pct, input logic [1:0] br,
                         input int abort_at, input bit expect_data);
    int   idx, cyc, tail;
    logic b_pend, cmd_done;
    aw_cycles = 0; done_cnt = 0; err_cnt = 0; rdy_outside = 0;
    timeout = 1'b0; err_with_done = 1'b0; rdy_at_done = 1'b0; resp_at_done = 2'b11;
    abort_snap = '1;
    exp_q.delete(); got_q.delete(); last_q.delete();
    for (int i = 0; i <= 256; i++) begin
      src[i] = DW'({$urandom, $urandom, $urandom, $urandom});
      if (expect_data && i <= int'(l)) exp_q.push_back(src[i]);
    end
    idx = 0; cyc = 0; tail = -1; b_pend = 1'b0; cmd_done = 1'b0;
    while (1) begin
      @(negedge clk);
      if (done) begin
        done_cnt++; resp_at_done = resp; rdy_at_done = cmd_ready; err_with_done = err;
      end
      if (err) err_cnt++;
      if (tail == 0) break;
      else if (tail > 0) tail--;
      else if (done || err) tail = 2;
      if (cyc >= 2000) begin timeout = 1'b1; break; end
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        abort_snap = {axi.awvalid, axi.wvalid, axi.bready, done, err, dat_ready};
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      cmd_valid   = !cmd_done;
      cmd_addr    = a;
      cmd_len     = l;
      axi.awready = ($urandom_range(99) >= aw_pct);
      axi.wready  = ($urandom_range(99) >= w_pct);
      dat_valid   = (idx <= int'(l)) && ($urandom_range(99) >= v_pct);
      dat         = src[idx];
      axi.bvalid  = b_pend;
      axi.bresp   = br;
      #1;
      if (cmd_valid && cmd_ready) cmd_done = 1'b1;
      if (axi.awvalid) begin
        aw_cycles++;
        seen_awaddr = axi.awaddr; seen_awlen = axi.awlen;
        seen_awsize = axi.awsize; seen_awburst = axi.awburst;
      end
      if (dat_ready && (axi.awvalid || axi.bready || cmd_ready)) rdy_outside++;
      if (axi.wvalid && axi.wready) begin
        got_q.push_back(axi.wdata);
        last_q.push_back(axi.wlast);
        if (axi.wlast) b_pend = 1'b1;
        idx++;
      end
      if (axi.bvalid && axi.bready) b_pend = 1'b0;
    end
    cmd_valid = 1'b0; dat_valid = 1'b0; axi.bvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valids: aw/w/b got %b want 000", {axi.awvalid, axi.wvalid, axi.bready}); end
    n_checks++; if ({done, err, dat_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: done/err/dat_ready got %b want 000", {done, err, dat_ready}); end
    n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %0d want 0", resp); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [DW-1:0] e, g;
    run_cmd(32'h1000, 8'd3, 0, 0, 0, 2'b00, -1, 1'b1);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: burst did not finish"); end
    n_checks++; if (aw_cycles != 1) begin n_fail++; $display("FAIL basic_aw_cycles: got %0d want 1", aw_cycles); end
    n_checks++; if (seen_awaddr !== 32'h1000 || seen_awlen !== 8'd3) begin
      n_fail++; $display("FAIL basic_aw_fields: addr %h len %0d want 1000 len 3", seen_awaddr, seen_awlen); end
    n_checks++; if (seen_awsize !== 3'd3 || seen_awburst !== 2'b01) begin
      n_fail++; $display("FAIL basic_aw_size_burst: size %0d burst %0d want 3/1", seen_awsize, seen_awburst); end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_beats: got %0d want 4", got_q.size()); end
    for (int i = 0; i < last_q.size(); i++) begin
      n_checks++; if (last_q[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_wlast[%0d]: got %b want %b", i, last_q[i], (i == 3)); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL basic_data: beat missing, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL basic_data: got %h want %h", g, e); end end
    end
    n_checks++; if (done_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL basic_done: done %0d err %0d want 1/0", done_cnt, err_cnt); end
    n_checks++; if (resp_at_done !== 2'b00) begin n_fail++; $display("FAIL basic_resp: got %0d want 0", resp_at_done); end
    n_checks++; if (rdy_outside != 0) begin n_fail++; $display("FAIL basic_rdy_outside: %0d cycles want 0", rdy_outside); end
  endtask

  task automatic test_stalls();
    logic [DW-1:0] e, g;
    run_cmd(32'h0000_2000, 8'd15, 50, 40, 40, 2'b00, -1, 1'b1);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: burst did not finish"); end
    n_checks++; if (got_q.size() != 16) begin n_fail++; $display("FAIL stall_beats: got %0d want 16", got_q.size()); end
    for (int i = 0; i < last_q.size(); i++) begin
      n_checks++; if (last_q[i] !== (i == 15)) begin n_fail++; $display("FAIL stall_wlast[%0d]: got %b want %b", i, last_q[i], (i == 15)); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL stall_data: beat missing, want %h", e); end
      else begin g = got_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL stall_data: got %h want %h", g, e); end end
    end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL stall_extra: %0d surplus beats", got_q.size()); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
    n_checks++; if (rdy_outside != 0) begin n_fail++; $display("FAIL stall_rdy_outside: %0d cycles want 0", rdy_outside); end
  endtask

  task automatic test_4k();
    run_cmd(32'h0000_0FF8, 8'd1, 0, 0, 0, 2'b00, -1, 1'b0);
    n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL cross4k_err: got %0d pulses want 1", err_cnt); end
    n_checks++; if (aw_cycles != 0 || got_q.size() != 0 || done_cnt != 0) begin
      n_fail++; $display("FAIL cross4k_traffic: aw %0d beats %0d done %0d want 0/0/0", aw_cycles, got_q.size(), done_cnt); end
    run_cmd(32'h0000_1004, 8'd0, 0, 0, 0, 2'b00, -1, 1'b0);
    n_checks++; if (err_cnt != 1 || aw_cycles != 0) begin
      n_fail++; $display("FAIL misalign: err %0d aw %0d want 1/0", err_cnt, aw_cycles); end
    run_cmd(32'h0000_0FF0, 8'd1, 0, 0, 0, 2'b00, -1, 1'b1);
    n_checks++; if (err_cnt != 0 || done_cnt != 1 || got_q.size() != 2) begin
      n_fail++; $display("FAIL page_end_ok: err %0d done %0d beats %0d want 0/1/2", err_cnt, done_cnt, got_q.size()); end
  endtask

  task automatic test_slverr();
    run_cmd(32'h0000_3000, 8'd2, 20, 20, 0, 2'b10, -1, 1'b1);
    n_checks++; if (done_cnt != 1 || err_cnt != 1) begin n_fail++; $display("FAIL slverr_counts: done %0d err %0d want 1/1", done_cnt, err_cnt); end
    n_checks++; if (err_with_done !== 1'b1) begin n_fail++; $display("FAIL slverr_same_cycle: err with done %b want 1", err_with_done); end
    n_checks++; if (resp_at_done !== 2'b10) begin n_fail++; $display("FAIL slverr_resp: got %0d want 2", resp_at_done); end
    n_checks++; if (rdy_at_done !== 1'b1) begin n_fail++; $display("FAIL slverr_cmd_ready: got %b want 1", rdy_at_done); end
    repeat (3) @(negedge clk);
    n_checks++; if (resp !== 2'b10) begin n_fail++; $display("FAIL slverr_resp_hold: got %0d want 2", resp); end
  endtask

  task automatic test_back_to_back();
    run_cmd(32'h0000_4000, 8'd0, 0, 0, 0, 2'b00, -1, 1'b1);
    n_checks++; if (done_cnt != 1 || resp_at_done !== 2'b00) begin
      n_fail++; $display("FAIL b2b_first: done %0d resp %0d want 1/0", done_cnt, resp_at_done); end
    run_cmd(32'h0000_4040, 8'd7, 0, 30, 0, 2'b00, -1, 1'b1);
    n_checks++; if (done_cnt != 1 || got_q.size() != 8 || seen_awaddr !== 32'h4040) begin
      n_fail++; $display("FAIL b2b_second: done %0d beats %0d addr %h want 1/8/4040", done_cnt, got_q.size(), seen_awaddr); end
  endtask

  task automatic test_reset_mid();
    run_cmd(32'h0000_5000, 8'd7, 0, 0, 0, 2'b00, 2, 1'b1);
    n_checks++; if (abort_snap !== 6'b000000) begin
      n_fail++; $display("FAIL abort_valids: aw/w/b/done/err/rdy got %b want 000000", abort_snap); end
    n_checks++; if (got_q.size() != 2 || done_cnt != 0) begin
      n_fail++; $display("FAIL abort_progress: beats %0d done %0d want 2/0", got_q.size(), done_cnt); end
    run_cmd(32'h0000_6000, 8'd0, 0, 0, 0, 2'b00, -1, 1'b1);
    n_checks++; if (timeout !== 1'b0 || done_cnt != 1 || err_cnt != 0) begin
      n_fail++; $display("FAIL after_abort_done: timeout %b done %0d err %0d want 0/1/0", timeout, done_cnt, err_cnt); end
    n_checks++; if (got_q.size() != 1 || last_q.size() != 1) begin
      n_fail++; $display("FAIL after_abort_beats: got %0d want 1", got_q.size()); end
    else if (last_q[0] !== 1'b1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL after_abort_beat: wlast %b data %h want 1 %h", last_q[0], got_q[0], exp_q[0]); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; dat = '0; dat_valid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    test_reset();
    test_basic();
    test_stalls();
    test_4k();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
